// File: rtl/constants_pkg.sv
// Machine-wide sizing constants shared by the execute-side units.
package constants_pkg;

    localparam int XLEN        = 32;
    localparam int MUL_LATENCY = 5;
    localparam int MUL_TAG_W   = 8;

endpackage

// File: rtl/instruction_pkg.sv
// Decoded-instruction types exchanged between decode, execute and memory.
package instruction_pkg;

    import constants_pkg::*;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef struct packed {
        mul_op_e                op;
        logic [XLEN-1:0]        rs1;
        logic [XLEN-1:0]        rs2;
        logic [4:0]             rd;
        logic [MUL_TAG_W-1:0]   tag;
    } mul_req_t;

    typedef struct packed {
        logic [XLEN-1:0]        result;
        logic [4:0]             rd;
        logic [MUL_TAG_W-1:0]   tag;
    } mul_rsp_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// Pipeline slice: one valid bit plus a W-bit payload.
// Latency: one cycle from in_* to out_*.
// Backpressure: en=0 holds valid and payload; clr drops valid even when en=0.
module mul_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    output logic [W-1:0] out_dat
);

    // Valid bit: flush beats stall, stall holds the bubble/op in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
        end else if (clr) begin
            out_vld <= 1'b0;
        end else if (en) begin
            out_vld <= in_vld;
        end
    end

    // Payload loads only with a live op, so it keeps its last value across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_dat <= '0;
        end else if (en && in_vld && !clr) begin
            out_dat <= in_dat;
        end
    end

endmodule

// File: rtl/mul_pipe.sv
// RV32M multiply unit (MUL/MULH/MULHSU/MULHU) beside execute, in-order results to memory.
// Latency: LATENCY cycles, fixed; one op accepted per cycle.
// Backpressure: stall_i freezes every stage (stall_o mirrors it to decode); flush_i kills all.
module mul_pipe
    import instruction_pkg::*;
#(
    parameter int LATENCY = constants_pkg::MUL_LATENCY,
    parameter int XLEN    = constants_pkg::XLEN,
    parameter int TAG_W   = constants_pkg::MUL_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  mul_op_e          op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [4:0]       rd_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [4:0]       rd_o,
    output logic [TAG_W-1:0] tag_o,
    output logic [31:0]      pend_mask_o
);

    // Chunk geometry: low chunk is H unsigned bits, high chunk is H+1 bits carrying the sign.
    localparam int H  = XLEN / 2;
    localparam int QW = 2 * H + 2;      // exact width of one chunk product
    // Only the low 2*XLEN bits of the product are ever selected, so the running sum
    // is kept modulo 2^(2*XLEN); each chunk product itself is computed at full width.
    localparam int PW = 2 * XLEN;
    localparam int K  = LATENCY - 2;    // number of accumulate stages
    localparam int KS = (K > 0) ? K : 1;

    typedef struct packed {
        mul_op_e          op;
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
        logic [XLEN:0]    a;
        logic [XLEN:0]    b;
        logic [PW-1:0]    acc;
    } stage_t;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
    } out_t;

    // Partial product idx (0: lo*lo, 1: hi(a)*lo(b), 2: lo(a)*hi(b), 3: hi*hi), aligned.
    function automatic logic [PW-1:0] part_prod(input logic [XLEN:0] a,
                                                input logic [XLEN:0] b,
                                                input int            idx);
        logic [H:0]           ax;
        logic [H:0]           bx;
        logic signed [QW-1:0] ae;
        logic signed [QW-1:0] be;
        logic signed [QW-1:0] p;
        int                   sh;
        ax = (idx == 1 || idx == 3) ? a[XLEN:H] : {1'b0, a[H-1:0]};
        bx = (idx == 2 || idx == 3) ? b[XLEN:H] : {1'b0, b[H-1:0]};
        ae = {{(QW-H-1){ax[H]}}, ax};
        be = {{(QW-H-1){bx[H]}}, bx};
        p  = ae * be;
        sh = (idx == 0) ? 0 : ((idx == 3) ? 2 * H : H);
        return {{(PW-QW){p[QW-1]}}, p} << sh;
    endfunction

    logic   adv;
    logic   vld  [0:LATENCY];
    stage_t st_q [1:LATENCY-1];
    stage_t prep;
    out_t   out_d;
    out_t   out_q;
    logic [PW-1:0] full;

    assign adv     = !stall_i;
    assign vld[0]  = valid_i;
    assign stall_o = stall_i;

    // Operand prep: extend to XLEN+1 bits; rs1 signed unless MULHU, rs2 signed for MUL/MULH.
    always_comb begin
        prep     = '0;
        prep.op  = op_i;
        prep.rd  = rd_i;
        prep.tag = tag_i;
        prep.a   = (op_i == MULHU) ? {1'b0, rs1_i} : {rs1_i[XLEN-1], rs1_i};
        prep.b   = (op_i == MUL || op_i == MULH) ? {rs2_i[XLEN-1], rs2_i} : {1'b0, rs2_i};
    end

    mul_pipe_reg #(.W($bits(stage_t))) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .clr     (flush_i),
        .in_vld  (vld[0]),
        .in_dat  (prep),
        .out_vld (vld[1]),
        .out_dat (st_q[1])
    );

    for (genvar i = 2; i <= LATENCY - 1; i++) begin : g_acc
        stage_t d;

        // Accumulate the partial products owned by this stage (round-robin over stages).
        always_comb begin
            d = st_q[i-1];
            for (int p = 0; p < 4; p++) begin
                if ((p % KS) == (i - 2)) begin
                    d.acc = d.acc + part_prod(st_q[i-1].a, st_q[i-1].b, p);
                end
            end
        end

        mul_pipe_reg #(.W($bits(stage_t))) u_acc (
            .clk     (clk),
            .rst     (rst),
            .en      (adv),
            .clr     (flush_i),
            .in_vld  (vld[i-1]),
            .in_dat  (d),
            .out_vld (vld[i]),
            .out_dat (st_q[i])
        );
    end

    // Result select: low word for MUL, high word otherwise (sum done here if no acc stages).
    always_comb begin
        out_d = '0;
        full  = st_q[LATENCY-1].acc;
        if (K == 0) begin
            for (int p = 0; p < 4; p++) begin
                full = full + part_prod(st_q[LATENCY-1].a, st_q[LATENCY-1].b, p);
            end
        end
        out_d.result = (st_q[LATENCY-1].op == MUL) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
        out_d.rd     = st_q[LATENCY-1].rd;
        out_d.tag    = st_q[LATENCY-1].tag;
    end

    mul_pipe_reg #(.W($bits(out_t))) u_out (
        .clk     (clk),
        .rst     (rst),
        .en      (adv),
        .clr     (flush_i),
        .in_vld  (vld[LATENCY-1]),
        .in_dat  (out_d),
        .out_vld (vld[LATENCY]),
        .out_dat (out_q)
    );

    assign valid_o  = vld[LATENCY];
    assign result_o = out_q.result;
    assign rd_o     = out_q.rd;
    assign tag_o    = out_q.tag;

    // Pending-rd mask: every live stage marks its destination; x0 never interlocks.
    always_comb begin
        pend_mask_o = '0;
        for (int i = 1; i < LATENCY; i++) begin
            if (vld[i] && st_q[i].rd != 5'd0) begin
                pend_mask_o[st_q[i].rd] = 1'b1;
            end
        end
        if (vld[LATENCY] && out_q.rd != 5'd0) begin
            pend_mask_o[out_q.rd] = 1'b1;
        end
    end

endmodule
